imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. Accepts one 32-bit instruction per cycle over a valid/ready handshake. Produces the sign- or zero-extended XLEN-wide immediate, a format code and an illegal-opcode flag one cycle later. A two-entry skid buffer gives full throughput under back-pressure and adds RV64 shift and OP-32 handling that the single-cycle combinational generator lacks.

---
 rtl/imm_gen_pipe_if.sv | 31 +++
 rtl/imm_gen_pipe.sv | 182 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: valid/ready bus bundle for the pipelined immediate generator.
// Parameters: XLEN (immediate width), TAG_W (sideband tag width).
// Upstream:   in_valid, in_ready, in_instr[31:0], in_tag[TAG_W-1:0]
// Downstream: out_valid, out_ready, out_imm[XLEN-1:0], out_fmt[2:0],
//             out_illegal, out_tag[TAG_W-1:0]
// modport slave is taken by the generator, modport master by its environment.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32/RV64 immediate generator with a two-entry skid
// buffer (main entry drives the outputs, skid entry absorbs back-pressure).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - synchronous drop of every buffered entry and same-cycle input
//   bus (slave) - in_* instruction handshake, out_* immediate/format/illegal/tag
// Optional feature: define IMMGEN_ZICSR_EN to decode CSR*I as format Z with
// the zero-extended uimm in instr[19:15].
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
`ifdef IMMGEN_ZICSR_EN
    localparam logic [2:0] FMT_Z = 3'd6;
`endif

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    entry_t main_q, main_d, skid_q, skid_d, new_e;
    logic   main_v, main_v_d, skid_v, skid_v_d;
    logic   in_ready_q;
    logic   push;

    assign instr    = bus.in_instr;
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign imm_i    = XLEN'($signed(instr[31:20]));

    // Opcode decode; anything not listed (including compressed encodings) is illegal.
    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_R;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0010011: begin
                dec_fmt = FMT_I;
                if (is_shift) begin
                    // funct7 must not leak into the shift amount
                    if (XLEN == 64) dec_imm = XLEN'(instr[25:20]);
                    else            dec_imm = XLEN'(instr[24:20]);
                end else begin
                    dec_imm = imm_i;
                end
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    dec_imm = is_shift ? XLEN'(instr[24:20]) : imm_i;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'b0000011, 7'b0001111, 7'b1100111: begin
                dec_fmt = FMT_I;
                dec_imm = imm_i;
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                         instr[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                         instr[30:21], 1'b0}));
            end
            7'b1110011: begin
`ifdef IMMGEN_ZICSR_EN
                if (funct3[2]) begin
                    dec_fmt = FMT_Z;
                    dec_imm = XLEN'(instr[19:15]);
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = imm_i;
                end
`else
                dec_fmt = FMT_I;
                dec_imm = imm_i;
`endif
            end
            7'b0110011: begin
                dec_fmt = FMT_R;
            end
            7'b0111011: begin
                dec_illegal = (XLEN != 64);
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign new_e = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: bus.in_tag};
    assign push  = bus.in_valid && in_ready_q;

    // Skid-buffer next state; flush wins, skid drains into main before new data.
    always_comb begin
        main_d   = main_q;
        main_v_d = main_v;
        skid_d   = skid_q;
        skid_v_d = skid_v;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v || bus.out_ready) begin
            if (skid_v) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = push;
                if (push) skid_d = new_e;
            end else if (push) begin
                main_d   = new_e;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (push) begin
            skid_d   = new_e;
            skid_v_d = 1'b1;
        end
    end

    // State registers; in_ready is its own flop so it never sees a comb path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_v     <= 1'b0;
            skid_q     <= '0;
            skid_v     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            main_v     <= main_v_d;
            skid_q     <= skid_d;
            skid_v     <= skid_v_d;
            in_ready_q <= !skid_v_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = main_v;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe with one XLEN=32 and one
// XLEN=64 instance sharing clock, reset and flush.
module tb_imm_gen_pipe;

    logic clk;
    logic rst_n;
    logic flush;

    int n_checks;
    int n_pass;
    logic [7:0] tag_cnt;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Present one instruction, step one edge, and expect its result right away.
    task automatic send32(input string name, input logic [31:0] ins,
                          input logic [31:0] e_imm, input logic [2:0] e_fmt,
                          input logic e_ill);
        bus32.in_valid = 1'b1;
        bus32.in_instr = ins;
        bus32.in_tag   = tag_cnt;
        @(posedge clk); #1;
        check({name, ".valid"},   64'(bus32.out_valid),   64'd1);
        check({name, ".imm"},     64'(bus32.out_imm),     64'(e_imm));
        check({name, ".fmt"},     64'(bus32.out_fmt),     64'(e_fmt));
        check({name, ".illegal"}, 64'(bus32.out_illegal), 64'(e_ill));
        check({name, ".tag"},     64'(bus32.out_tag),     64'(tag_cnt));
        tag_cnt++;
    endtask

    task automatic send64(input string name, input logic [31:0] ins,
                          input logic [63:0] e_imm, input logic [2:0] e_fmt,
                          input logic e_ill);
        bus64.in_valid = 1'b1;
        bus64.in_instr = ins;
        bus64.in_tag   = tag_cnt;
        @(posedge clk); #1;
        check({name, ".valid"},   64'(bus64.out_valid),   64'd1);
        check({name, ".imm"},     bus64.out_imm,          e_imm);
        check({name, ".fmt"},     64'(bus64.out_fmt),     64'(e_fmt));
        check({name, ".illegal"}, 64'(bus64.out_illegal), 64'(e_ill));
        tag_cnt++;
    endtask

    task automatic push_tag32(input logic [7:0] t);
        bus32.in_valid = 1'b1;
        bus32.in_instr = 32'hFFF00093;
        bus32.in_tag   = t;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        tag_cnt  = 8'd1;
        rst_n    = 1'b0;
        flush    = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.in_instr  = '0;
        bus32.in_tag    = '0;
        bus32.out_ready = 1'b1;
        bus64.in_valid  = 1'b0;
        bus64.in_instr  = '0;
        bus64.in_tag    = '0;
        bus64.out_ready = 1'b1;

        #12;
        check("rst.valid",    64'(bus32.out_valid),   64'd0);
        check("rst.in_ready", 64'(bus32.in_ready),    64'd1);
        check("rst.imm",      64'(bus32.out_imm),     64'd0);
        check("rst.fmt",      64'(bus32.out_fmt),     64'd0);
        check("rst.illegal",  64'(bus32.out_illegal), 64'd0);
        check("rst.tag",      64'(bus32.out_tag),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel.valid",    64'(bus32.out_valid),   64'd0);
        check("rel.in_ready", 64'(bus32.in_ready),    64'd1);

        // Back-to-back decode on the 32-bit instance
        send32("addi_m1", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
        send32("lui",     32'h123450B7, 32'h12345000, 3'd4, 1'b0);
        send32("jal_m4",  32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0);
        send32("beq_m8",  32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0);
        send32("sw_m4",   32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0);
        send32("srai3",   32'h4030D093, 32'h00000003, 3'd1, 1'b0);
        send32("opimm32", 32'h0000001B, 32'h00000000, 3'd0, 1'b1);
        send32("add",     32'h002081B3, 32'h00000000, 3'd0, 1'b0);
        send32("addw32",  32'h0020803B, 32'h00000000, 3'd0, 1'b1);
        send32("cmp16",   32'h00000001, 32'h00000000, 3'd0, 1'b1);
`ifdef IMMGEN_ZICSR_EN
        send32("csrrwi",  32'h3002D073, 32'h00000005, 3'd6, 1'b0);
`else
        send32("csrrwi",  32'h3002D073, 32'h00000300, 3'd1, 1'b0);
`endif
        bus32.in_valid = 1'b0;

        // 64-bit instance
        send64("addi64",  32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        send64("slli63",  32'h03F09093, 64'd63, 3'd1, 1'b0);
        send64("srai64",  32'h4030D093, 64'd3,  3'd1, 1'b0);
        send64("addiw",   32'h0010809B, 64'd1,  3'd1, 1'b0);
        send64("addw",    32'h0020803B, 64'd0,  3'd0, 1'b0);
        send64("lui64",   32'hFFFFF0B7, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0);
        bus64.in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain.valid", 64'(bus32.out_valid), 64'd0);

        // Back-pressure: tags 1,2,3 with out_ready low
        bus32.out_ready = 1'b0;
        push_tag32(8'd1);
        @(posedge clk); #1;
        check("bp1.tag",      64'(bus32.out_tag),  64'd1);
        check("bp1.in_ready", 64'(bus32.in_ready), 64'd1);
        push_tag32(8'd2);
        @(posedge clk); #1;
        check("bp2.in_ready", 64'(bus32.in_ready), 64'd0);
        check("bp2.tag",      64'(bus32.out_tag),  64'd1);
        push_tag32(8'd3);
        @(posedge clk); #1;
        check("bp3.in_ready", 64'(bus32.in_ready), 64'd0);
        check("bp3.tag",      64'(bus32.out_tag),  64'd1);
        check("bp3.imm",      64'(bus32.out_imm),  64'hFFFFFFFF);
        check("bp3.valid",    64'(bus32.out_valid), 64'd1);
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        check("rel2.tag",      64'(bus32.out_tag),   64'd2);
        check("rel2.in_ready", 64'(bus32.in_ready),  64'd1);
        @(posedge clk); #1;
        check("rel3.tag",      64'(bus32.out_tag),   64'd3);
        check("rel3.valid",    64'(bus32.out_valid), 64'd1);
        bus32.in_valid = 1'b0;
        @(posedge clk); #1;
        check("rel.empty",     64'(bus32.out_valid), 64'd0);

        // Flush with both entries full and input pending
        bus32.out_ready = 1'b0;
        push_tag32(8'd4);
        @(posedge clk); #1;
        push_tag32(8'd5);
        @(posedge clk); #1;
        check("full.in_ready", 64'(bus32.in_ready), 64'd0);
        push_tag32(8'd6);
        flush = 1'b1;
        @(posedge clk); #1;
        check("fl.valid",    64'(bus32.out_valid), 64'd0);
        check("fl.in_ready", 64'(bus32.in_ready),  64'd1);
        flush = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        check("fl.dropped",  64'(bus32.out_valid), 64'd0);

        // Flush while accepting: the same-cycle input must be dropped
        bus32.out_ready = 1'b0;
        push_tag32(8'd7);
        @(posedge clk); #1;
        push_tag32(8'd8);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        check("fl2.valid",   64'(bus32.out_valid), 64'd0);
        @(posedge clk); #1;
        check("fl2.dropped", 64'(bus32.out_valid), 64'd0);

        // Asynchronous reset mid-stream
        push_tag32(8'd9);
        @(posedge clk); #1;
        check("pre.valid", 64'(bus32.out_valid), 64'd1);
        check("pre.tag",   64'(bus32.out_tag),   64'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid",    64'(bus32.out_valid),   64'd0);
        check("arst.imm",      64'(bus32.out_imm),     64'd0);
        check("arst.tag",      64'(bus32.out_tag),     64'd0);
        check("arst.illegal",  64'(bus32.out_illegal), 64'd0);
        check("arst.in_ready", 64'(bus32.in_ready),    64'd1);
        bus32.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post.valid", 64'(bus32.out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
